// File: rtl/aes_iter_pkg.sv
// rtl/aes_iter_pkg.sv - shared types, S-box and byte helpers for the iterative AES encryptor
// Contents:
//   aes_mode_e  : per-block chaining mode (ECB, CBC-continue, CBC-start, reserved)
//   aes_state_e : engine FSM state
//   nr()        : round count for a key length
//   sbox(), xtime(), mix_column(), get_byte() : AES primitives in FIPS-197 byte order
//                 (block bits 127:120 hold byte 0, column c holds bytes 4c..4c+3)
package aes_iter_pkg;

  typedef enum logic [1:0] {
    MODE_ECB       = 2'd0,
    MODE_CBC_CONT  = 2'd1,
    MODE_CBC_START = 2'd2,
    MODE_RSVD      = 2'd3
  } aes_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

  function automatic int nr(input int keylen);
    return keylen / 32 + 6;
  endfunction

  // Entry 0 is the leftmost byte so SBOX[b] is the substitution of b.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] blk, input int n);
    return blk[127-8*n -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // col[31:24] is row 0 of the column.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// rtl/aes_round_comb.sv - one combinational AES encryption round
// Ports:
//   state_in  : 128-bit state, FIPS-197 byte order
//   round_key : round key for this round
//   last      : 1 = final round, MixColumns bypassed
//   state_out : SubBytes -> ShiftRows -> [MixColumns] -> AddRoundKey
module aes_round_comb
  import aes_iter_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] sub_b;
  logic [127:0] shift_b;
  logic [127:0] mix_b;

  always_comb begin
    sub_b   = '0;
    shift_b = '0;
    mix_b   = '0;
    for (int n = 0; n < 16; n++) begin
      sub_b[127-8*n -: 8] = sbox(get_byte(state_in, n));
    end
    // Row r rotates left by r columns: out(r,c) = in(r, c+r mod 4).
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_b[127-8*(4*c+r) -: 8] = get_byte(sub_b, 4*((c+r)%4)+r);
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix_b[127-32*c -: 32] = mix_column(shift_b[127-32*c -: 32]);
    end
    state_out = (last ? shift_b : mix_b) ^ round_key;
  end

endmodule

// File: rtl/aes_block_encrypt_iter.sv
// rtl/aes_block_encrypt_iter.sv - iterative one-round-per-cycle AES encryptor with ECB/CBC chaining
// Ports:
//   clk, rst (sync, active-low)
//   valid_in/ready_in   : block input handshake; mode_in, iv_in, tag_in, plaintext ride with it
//   expanded_key        : NR+1 round keys, must stay stable until the result is consumed
//   valid_out/ready_out : result handshake; ciphertext and tag_out hold the last result
module aes_block_encrypt_iter
  import aes_iter_pkg::*;
#(
  parameter int KEYLEN = 128,
  parameter int TAGW   = 8,
  localparam int NR    = nr(KEYLEN),
  localparam int CW    = $clog2(NR + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [1:0]              mode_in,
  input  logic [127:0]            iv_in,
  input  logic [TAGW-1:0]         tag_in,
  input  logic [3:0][3:0][7:0]    plaintext,
  input  logic [NR:0][127:0]      expanded_key,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [3:0][3:0][7:0]    ciphertext,
  output logic [TAGW-1:0]         tag_out
);

  aes_state_e      st;
  aes_mode_e       mode_q;
  logic [CW-1:0]   round_ctr;
  logic [127:0]    blk;
  logic [127:0]    chain;
  logic [TAGW-1:0] tag_q;

  logic [127:0]    chain_x;
  logic [127:0]    load_blk;
  logic [127:0]    round_key;
  logic [127:0]    round_out;
  logic            last_round;
  logic            accept;
  logic            mode_cbc;

  // In DONE a new block can only enter in the same cycle the result leaves.
  assign ready_in   = (st == ST_IDLE) || ((st == ST_DONE) && ready_out);
  assign accept     = valid_in && ready_in;
  assign round_key  = expanded_key[round_ctr];
  assign last_round = (round_ctr == CW'(NR));
  assign mode_cbc   = (mode_q == MODE_CBC_CONT) || (mode_q == MODE_CBC_START);

  always_comb begin
    chain_x = '0;
    case (aes_mode_e'(mode_in))
      MODE_CBC_CONT:  chain_x = chain;
      MODE_CBC_START: chain_x = iv_in;
      default:        chain_x = '0;
    endcase
  end

  assign load_blk = plaintext ^ chain_x ^ expanded_key[0];

  aes_round_comb u_round (
    .state_in  (blk),
    .round_key (round_key),
    .last      (last_round),
    .state_out (round_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      st         <= ST_IDLE;
      mode_q     <= MODE_ECB;
      round_ctr  <= '0;
      blk        <= '0;
      chain      <= '0;
      tag_q      <= '0;
      valid_out  <= 1'b0;
      ciphertext <= '0;
      tag_out    <= '0;
    end else if (accept) begin
      st        <= ST_ROUND;
      blk       <= load_blk;
      round_ctr <= CW'(1);
      tag_q     <= tag_in;
      mode_q    <= aes_mode_e'(mode_in);
      valid_out <= 1'b0;
    end else begin
      case (st)
        ST_ROUND: begin
          blk <= round_out;
          if (last_round) begin
            st         <= ST_DONE;
            valid_out  <= 1'b1;
            ciphertext <= round_out;
            tag_out    <= tag_q;
            if (mode_cbc) begin
              chain <= round_out;
            end
          end else begin
            round_ctr <= round_ctr + CW'(1);
          end
        end
        ST_DONE: begin
          if (ready_out) begin
            st        <= ST_IDLE;
            valid_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_encrypt_iter.sv
// tb/tb_aes_block_encrypt_iter.sv - self-checking bench for aes_block_encrypt_iter
module tb_aes_block_encrypt_iter;
  import aes_iter_pkg::*;

  typedef logic [14:0][127:0] ek_t;
  typedef struct {
    logic [127:0] ct;
    logic [7:0]   tag;
    int           acc;
  } exp_t;
  typedef struct {
    logic [1:0]   mode;
    logic [255:0] key;
    logic [127:0] iv;
    logic [127:0] pt;
    logic [7:0]   tag;
    logic [127:0] ct;
  } vec_t;

  localparam logic [127:0] KA   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PA   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CA   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1   = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2   = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;
  logic v_in, rdy_in, v_out, rdy_out;
  logic [1:0] mode;
  logic [127:0] iv, pt, ct;
  logic [7:0] tag, tag_o;
  logic [10:0][127:0] ek;

  logic v_in_b, rdy_in_b, v_out_b, rdy_out_b;
  logic [127:0] pt_b, ct_b;
  logic [7:0] tag_o_b;
  logic [14:0][127:0] ek_b;

  aes_block_encrypt_iter #(.KEYLEN(128), .TAGW(8)) dut (
    .clk(clk), .rst(rst), .valid_in(v_in), .ready_in(rdy_in), .mode_in(mode),
    .iv_in(iv), .tag_in(tag), .plaintext(pt), .expanded_key(ek), .valid_out(v_out),
    .ready_out(rdy_out), .ciphertext(ct), .tag_out(tag_o)
  );

  aes_block_encrypt_iter #(.KEYLEN(256), .TAGW(8)) dut256 (
    .clk(clk), .rst(rst), .valid_in(v_in_b), .ready_in(rdy_in_b), .mode_in(2'd0),
    .iv_in(128'h0), .tag_in(8'ha5), .plaintext(pt_b), .expanded_key(ek_b), .valid_out(v_out_b),
    .ready_out(rdy_out_b), .ciphertext(ct_b), .tag_out(tag_o_b)
  );

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  logic [7:0] sb [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic hi;
    p = 8'h0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic ek_t expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    int nrr;
    ek_t e;
    nrr = nk + 6; rc = 8'h01; e = '0;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nrr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nrr; r++) e[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return e;
  endfunction

  function automatic logic [127:0] ref_enc(input ek_t e, input int nrr, input logic [127:0] p);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int n = 0; n < 16; n++) s[n] = p[127-8*n -: 8] ^ e[0][127-8*n -: 8];
    for (int r = 1; r <= nrr; r++) begin
      for (int n = 0; n < 16; n++) s[n] = sb[s[n]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c+w)%4)+w];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          if (r < nrr)
            s[4*c+w] = gmul(8'h02, t[4*c+w]) ^ gmul(8'h03, t[4*c+(w+1)%4])
                     ^ t[4*c+(w+2)%4] ^ t[4*c+(w+3)%4];
          else
            s[4*c+w] = t[4*c+w];
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ e[r][127-8*n -: 8];
    end
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
    return o;
  endfunction

  // Drives a block, waits for ready_in, records the accept cycle and the expected result.
  task automatic send(input logic [1:0] m, input logic [127:0] ivv, input logic [127:0] ptv,
                      input logic [7:0] tg, input logic [127:0] exp_ct, output int acc);
    int n;
    mode = m; iv = ivv; pt = ptv; tag = tg; v_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_in && n < 100);
    if (!rdy_in) begin
      chk("send_ready_timeout", {127'h0, rdy_in}, 128'h1);
      v_in = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    v_in = 1'b0;
    acc = cyc;
    sbq.push_back('{ct: exp_ct, tag: tg, acc: cyc});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", 128'(sbq.size()), 128'h0);
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pops on every output handshake of the AES-128 instance.
  initial begin
    logic prev_v;
    int first_cyc;
    exp_t e;
    prev_v = 1'b0;
    first_cyc = 0;
    forever begin
      @(negedge clk);
      if (v_out && !prev_v) first_cyc = cyc;
      prev_v = v_out;
      if (v_out && rdy_out) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%h required=no_output", ct);
        end else begin
          e = sbq.pop_front();
          chk("sb_ct", ct, e.ct);
          chk("sb_tag", {120'h0, tag_o}, {120'h0, e.tag});
          chk("sb_latency", 128'(first_cyc - e.acc + 1), 128'd11);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    ek_t eka, ekb, tmp;
    logic [127:0] exp_ct;
    int acc, n, seen, lat;
    int accs [4];

    rst = 1'b0; v_in = 1'b0; rdy_out = 1'b1; mode = 2'd0; iv = '0; pt = '0; tag = '0; ek = '0;
    v_in_b = 1'b0; rdy_out_b = 1'b1; pt_b = '0; ek_b = '0;

    // S-box from the GF(2^8) inverse and affine map.
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
      sb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    eka = expand({KA, 128'h0}, 4);
    ekb = expand({KB, 128'h0}, 4);

    tbl[0] = '{MODE_ECB,       {KA, 128'h0}, 128'h0, PA, 8'h5a, CA};
    tbl[1] = '{MODE_CBC_START, {KB, 128'h0}, IV1,    P1, 8'h01, C1};
    tbl[2] = '{MODE_ECB,       {KB, 128'h0}, {4{32'hffff0000}}, PA, 8'h02, ref_enc(ekb, 10, PA)};
    tbl[3] = '{MODE_CBC_CONT,  {KB, 128'h0}, {4{32'hdeadbeef}}, P2, 8'h03, C2};
    tbl[4] = '{MODE_RSVD,      {KA, 128'h0}, {4{32'h12345678}}, PA, 8'h04, CA};
    tbl[5] = '{MODE_CBC_CONT,  {KB, 128'h0}, {4{32'hdeadbeef}}, P1, 8'h05, ref_enc(ekb, 10, P1 ^ C2)};
    tbl[6] = '{MODE_CBC_START, {KB, 128'h0}, {4{32'hffffffff}}, PA, 8'h06, ref_enc(ekb, 10, ~PA)};

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_valid_out", {127'h0, v_out}, 128'h0);
    chk("rst_ready_in", {127'h0, rdy_in}, 128'h1);
    chk("rst_ciphertext", ct, 128'h0);
    chk("rst_tag_out", {120'h0, tag_o}, 128'h0);
    chk("rst256_valid_out", {127'h0, v_out_b}, 128'h0);
    chk("rst256_ready_in", {127'h0, rdy_in_b}, 128'h1);
    chk("rst256_ciphertext", ct_b, 128'h0);

    // AES-256 known answer and latency.
    @(posedge clk);
    #1;
    tmp = expand(K256, 8);
    ek_b = tmp;
    pt_b = PA;
    v_in_b = 1'b1;
    @(posedge clk);
    #1;
    v_in_b = 1'b0;
    acc = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!v_out_b && n < 40);
    lat = cyc - acc + 1;
    chk("aes256_valid", {127'h0, v_out_b}, 128'h1);
    chk("aes256_latency", 128'(lat), 128'd15);
    chk("aes256_ct", ct_b, C256);
    chk("aes256_tag", {120'h0, tag_o_b}, 128'ha5);
    @(posedge clk);
    #1;

    // Mode/chaining table on the AES-128 instance.
    for (int i = 0; i < 7; i++) begin
      tmp = expand(tbl[i].key, 4);
      ek = tmp[10:0];
      send(tbl[i].mode, tbl[i].iv, tbl[i].pt, tbl[i].tag, tbl[i].ct, acc);
      drain();
    end

    // Backpressure: 7 stalled cycles in DONE with a block pending on the input.
    ek = eka[10:0];
    rdy_out = 1'b0;
    send(MODE_ECB, 128'h0, PA, 8'h33, CA, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!v_out && n < 40);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid_out", {127'h0, v_out}, 128'h1);
      chk("bp_ciphertext", ct, CA);
      chk("bp_tag_out", {120'h0, tag_o}, 128'h33);
      chk("bp_ready_in", {127'h0, rdy_in}, 128'h0);
      @(posedge clk);
      #1;
      if (i == 0) begin
        mode = MODE_ECB; iv = '0; pt = P2; tag = 8'h44; v_in = 1'b1;
      end
    end
    rdy_out = 1'b1;
    @(negedge clk);
    chk("bp_release_ready_in", {127'h0, rdy_in}, 128'h1);
    @(posedge clk);
    #1;
    v_in = 1'b0;
    sbq.push_back('{ct: ref_enc(eka, 10, P2), tag: 8'h44, acc: cyc});
    drain();

    // Back-to-back ECB blocks with ready_out held high.
    for (int k = 0; k < 4; k++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      exp_ct = ref_enc(eka, 10, pt);
      send(MODE_ECB, 128'h0, pt, 8'(k), exp_ct, accs[k]);
    end
    drain();
    for (int k = 1; k < 4; k++) chk("b2b_period", 128'(accs[k] - accs[k-1]), 128'd11);

    // Reset during round 5 aborts the block and clears the chain.
    ek = ekb[10:0];
    send(MODE_CBC_START, IV1, P1, 8'h61, C1, acc);
    drain();
    send(MODE_CBC_START, IV1, P2, 8'h62, ref_enc(ekb, 10, P2 ^ IV1), acc);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    void'(sbq.pop_back());
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (v_out) seen++;
    end
    chk("abort_no_valid", 128'(seen), 128'h0);
    chk("abort_ready_in", {127'h0, rdy_in}, 128'h1);
    chk("abort_ciphertext", ct, 128'h0);
    chk("abort_tag_out", {120'h0, tag_o}, 128'h0);
    @(posedge clk);
    #1;
    send(MODE_CBC_CONT, {4{32'hdeadbeef}}, PA, 8'h63, ref_enc(ekb, 10, PA), acc);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
